// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg - shared definitions for the multi-cycle MIPS main control.
//   Opcode constants, FSM state encoding, ALU operation codes and the
//   ALU-B / PC-source mux encodings used by mips_mc_ctrl and mips_op_decode.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'h0,
    ST_DECODE   = 4'h1,
    ST_R_EXEC   = 4'h2,
    ST_R_WB     = 4'h3,
    ST_MEM_ADDR = 4'h4,
    ST_MEM_RD   = 4'h5,
    ST_MEM_WB   = 4'h6,
    ST_MEM_WR   = 4'h7,
    ST_BRANCH   = 4'h8,
    ST_JUMP     = 4'h9,
    ST_I_EXEC   = 4'hA,
    ST_I_WB     = 4'hB,
    ST_TRAP     = 4'hF
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd6;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // States that own a memory request and may stall on mem_ready.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_op_decode.sv
// mips_op_decode - combinational opcode classifier for the main control.
//   opcode_i      : IR[31:26]
//   next_state_o  : state to enter after DECODE (ST_TRAP when unsupported)
//   imm_alu_op_o  : ALU operation for the immediate-format arithmetic ops
//   is_bne_o      : branch polarity (1 = bne, 0 = beq)
//   illegal_o     : opcode outside the supported instruction set
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [3:0] next_state_o,
  output logic [2:0] imm_alu_op_o,
  output logic       is_bne_o,
  output logic       illegal_o
);

  always_comb begin
    next_state_o = ST_TRAP;
    imm_alu_op_o = ALU_ADD;
    is_bne_o     = (opcode_i == OP_BNE);
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE:      next_state_o = ST_R_EXEC;
      OP_LW, OP_SW:  next_state_o = ST_MEM_ADDR;
      OP_BEQ, OP_BNE: next_state_o = ST_BRANCH;
      OP_J:          next_state_o = ST_JUMP;
      OP_ADDI: begin
        next_state_o = ST_I_EXEC;
        imm_alu_op_o = ALU_ADD;
      end
      OP_SLTI: begin
        next_state_o = ST_I_EXEC;
        imm_alu_op_o = ALU_SLT;
      end
      OP_ANDI: begin
        next_state_o = ST_I_EXEC;
        imm_alu_op_o = ALU_AND;
      end
      OP_ORI: begin
        next_state_o = ST_I_EXEC;
        imm_alu_op_o = ALU_OR;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl - main control FSM for the multi-cycle MIPS datapath.
//   Inputs : clk, rst_n (sync, active low), opcode (IR[31:26]), zero (ALU
//            flag), mem_ready (memory finishes the current access)
//   Outputs: datapath enables/selects (pc_write, pc_src, i_or_d, mem_read,
//            mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//            alu_src_a, alu_src_b), ALU control (alu_op, use_funct),
//            sticky illegal trap flag and the debug state.
//   MEM_TIMEOUT: max stall cycles on one memory access before trapping
//            (0 disables the timeout).
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   FETCH    | read instruction at PC, PC+4 -> PC when memory ready
//   DECODE   | branch target -> ALUOut, classify opcode
//   R_EXEC   | rs op rt, ALU control decodes funct
//   R_WB     | ALUOut -> rd
//   MEM_ADDR | rs + imm -> ALUOut (load/store address)
//   MEM_RD   | data read at ALUOut, wait for memory
//   MEM_WB   | MDR -> rt
//   MEM_WR   | rt written at ALUOut, wait for memory
//   BRANCH   | rs - rt, conditional PC load from ALUOut
//   JUMP     | jump target -> PC
//   I_EXEC   | rs op imm
//   I_WB     | ALUOut -> rt
//   TRAP     | illegal opcode / memory timeout, parked until reset
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       use_funct,
  output logic       illegal,
  output logic [3:0] state
);

  // Counter only needs to reach MEM_TIMEOUT-1; the next stalled cycle traps.
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] dec_next;
  logic [2:0] dec_imm_alu_op;
  logic       dec_is_bne;
  logic       dec_illegal;
  logic       mem_stall;
  logic       timeout_hit;

  mips_op_decode u_op_decode (
    .opcode_i     (opcode),
    .next_state_o (dec_next),
    .imm_alu_op_o (dec_imm_alu_op),
    .is_bne_o     (dec_is_bne),
    .illegal_o    (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == ST_TRAP);
      cnt_q     <= cnt_d;
    end
  end

  assign mem_stall   = is_mem_state(state_q) && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_stall && (cnt_q == CNT_LAST);
  assign state       = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    use_funct  = 1'b0;
    illegal    = illegal_q;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        state_d   = dec_illegal ? ST_TRAP : state_e'(dec_next);
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        use_funct = 1'b1;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        use_funct = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = dec_is_bne ? !zero : zero;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = dec_imm_alu_op;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        alu_op    = dec_imm_alu_op;
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    // A stalled access that has used up its budget traps; ready on the
    // same cycle takes precedence because mem_stall is then false.
    if (timeout_hit) state_d = ST_TRAP;

    if (!rst_n) begin
      pc_write   = 1'b0;
      pc_src     = PCSRC_ALU;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALU_ADD;
      use_funct  = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if ((MEM_TIMEOUT > 0) && mem_stall) cnt_d = cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl - directed bench for mips_mc_ctrl.
//   dut0: MEM_TIMEOUT=0 (wait forever), walks every instruction class.
//   dut1: MEM_TIMEOUT=4, store timeout and ready-wins cases.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       use_funct;
    logic       illegal;
  } cw_t;

  localparam cw_t CW_ZERO      = '0;
  localparam cw_t CW_FETCH_RDY = '{pc_write:1'b1, ir_write:1'b1, mem_read:1'b1, alu_src_b:2'd1, default:'0};
  localparam cw_t CW_FETCH_WT  = '{mem_read:1'b1, alu_src_b:2'd1, default:'0};
  localparam cw_t CW_DECODE    = '{alu_src_b:2'd3, default:'0};
  localparam cw_t CW_R_EXEC    = '{alu_src_a:1'b1, use_funct:1'b1, default:'0};
  localparam cw_t CW_R_WB      = '{reg_dst:1'b1, reg_write:1'b1, use_funct:1'b1, default:'0};
  localparam cw_t CW_MEM_ADDR  = '{alu_src_a:1'b1, alu_src_b:2'd2, default:'0};
  localparam cw_t CW_MEM_RD    = '{i_or_d:1'b1, mem_read:1'b1, default:'0};
  localparam cw_t CW_MEM_WB    = '{mem_to_reg:1'b1, reg_write:1'b1, default:'0};
  localparam cw_t CW_MEM_WR    = '{i_or_d:1'b1, mem_write:1'b1, default:'0};
  localparam cw_t CW_BR_TAKEN  = '{pc_write:1'b1, pc_src:2'd1, alu_src_a:1'b1, alu_op:3'd1, default:'0};
  localparam cw_t CW_BR_NOT    = '{pc_src:2'd1, alu_src_a:1'b1, alu_op:3'd1, default:'0};
  localparam cw_t CW_JUMP      = '{pc_write:1'b1, pc_src:2'd2, default:'0};
  localparam cw_t CW_TRAP      = '{illegal:1'b1, default:'0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, use_funct, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] st0;

  logic       rst_n1, zero1, mem_ready1;
  logic [5:0] opcode1;
  logic       t_pc_write, t_i_or_d, t_mem_read, t_mem_write, t_ir_write, t_reg_dst;
  logic       t_mem_to_reg, t_reg_write, t_alu_src_a, t_use_funct, t_illegal;
  logic [1:0] t_pc_src, t_alu_src_b;
  logic [2:0] t_alu_op;
  logic [3:0] st1;

  cw_t cw0, cw1, e;
  int  n_assert = 0;
  int  n_fail   = 0;

  logic [5:0] i_ops [4] = '{OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};
  logic [2:0] i_alu [4] = '{3'd0, 3'd6, 3'd2, 3'd3};

  mips_mc_ctrl #(.MEM_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .use_funct(use_funct),
    .illegal(illegal), .state(st0)
  );

  mips_mc_ctrl #(.MEM_TIMEOUT(4)) dut1 (
    .clk(clk), .rst_n(rst_n1), .opcode(opcode1), .zero(zero1), .mem_ready(mem_ready1),
    .pc_write(t_pc_write), .pc_src(t_pc_src), .i_or_d(t_i_or_d), .mem_read(t_mem_read),
    .mem_write(t_mem_write), .ir_write(t_ir_write), .reg_dst(t_reg_dst),
    .mem_to_reg(t_mem_to_reg), .reg_write(t_reg_write), .alu_src_a(t_alu_src_a),
    .alu_src_b(t_alu_src_b), .alu_op(t_alu_op), .use_funct(t_use_funct),
    .illegal(t_illegal), .state(st1)
  );

  assign cw0 = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, use_funct, illegal};
  assign cw1 = {t_pc_write, t_pc_src, t_i_or_d, t_mem_read, t_mem_write, t_ir_write,
                t_reg_dst, t_mem_to_reg, t_reg_write, t_alu_src_a, t_alu_src_b,
                t_alu_op, t_use_funct, t_illegal};

  task automatic chk_cw(input string tag, input cw_t obs, input cw_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: controls observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: state observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [3:0] es, input cw_t ec);
    chk_st(tag, st0, es);
    chk_cw(tag, cw0, ec);
  endtask

  task automatic chk1(input string tag, input logic [3:0] es, input cw_t ec);
    chk_st(tag, st1, es);
    chk_cw(tag, cw1, ec);
  endtask

  // Advance dut0 one cycle: new inputs at negedge, sample 1 ns later.
  task automatic cyc(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  task automatic cyc1(input logic rdy);
    @(negedge clk);
    mem_ready1 = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;
    rst_n1 = 1'b0; opcode1 = OP_SW; zero1 = 1'b0; mem_ready1 = 1'b1;

    // reset held two cycles
    @(negedge clk); #1;
    chk_cw("rst_c0", cw0, CW_ZERO);
    @(negedge clk); #1;
    chk0("rst_c1", ST_FETCH, CW_ZERO);

    // add
    @(negedge clk); rst_n = 1'b1; #1;
    chk0("add_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc(1); chk0("add_dec", ST_DECODE, CW_DECODE);
    cyc(1); chk0("add_exec", ST_R_EXEC, CW_R_EXEC);
    cyc(1); chk0("add_wb", ST_R_WB, CW_R_WB);

    // lw with three stall cycles
    cyc(1); opcode = OP_LW; chk0("lw_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc(1); chk0("lw_dec", ST_DECODE, CW_DECODE);
    cyc(1); chk0("lw_addr", ST_MEM_ADDR, CW_MEM_ADDR);
    for (int i = 0; i < 3; i++) begin
      cyc(0); chk0("lw_rd_wait", ST_MEM_RD, CW_MEM_RD);
    end
    cyc(1); chk0("lw_rd_done", ST_MEM_RD, CW_MEM_RD);
    cyc(1); chk0("lw_wb", ST_MEM_WB, CW_MEM_WB);

    // beq, taken then not-taken within the same cycle
    cyc(1); opcode = OP_BEQ; zero = 1'b1; chk0("beq_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc(1); chk0("beq_dec", ST_DECODE, CW_DECODE);
    cyc(1); chk0("beq_z1", ST_BRANCH, CW_BR_TAKEN);
    zero = 1'b0; #1; chk0("beq_z0", ST_BRANCH, CW_BR_NOT);

    // bne
    cyc(1); opcode = OP_BNE; zero = 1'b1; chk0("bne_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc(1); chk0("bne_dec", ST_DECODE, CW_DECODE);
    cyc(1); chk0("bne_z1", ST_BRANCH, CW_BR_NOT);
    zero = 1'b0; #1; chk0("bne_z0", ST_BRANCH, CW_BR_TAKEN);

    // j
    cyc(1); opcode = OP_J; chk0("j_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc(1); chk0("j_dec", ST_DECODE, CW_DECODE);
    cyc(1); chk0("j_jump", ST_JUMP, CW_JUMP);

    // immediate arithmetic
    for (int k = 0; k < 4; k++) begin
      cyc(1); opcode = i_ops[k]; chk0("imm_fetch", ST_FETCH, CW_FETCH_RDY);
      cyc(1); chk0("imm_dec", ST_DECODE, CW_DECODE);
      cyc(1);
      e = CW_MEM_ADDR; e.alu_op = i_alu[k];
      chk0("imm_exec", ST_I_EXEC, e);
      cyc(1);
      e = CW_ZERO; e.reg_write = 1'b1; e.alu_op = i_alu[k];
      chk0("imm_wb", ST_I_WB, e);
    end

    // sw after a long fetch stall; no timeout on dut0
    for (int i = 0; i < 6; i++) begin
      cyc(0); opcode = OP_SW; chk0("sw_fetch_wait", ST_FETCH, CW_FETCH_WT);
    end
    cyc(1); chk0("sw_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc(1); chk0("sw_dec", ST_DECODE, CW_DECODE);
    cyc(1); chk0("sw_addr", ST_MEM_ADDR, CW_MEM_ADDR);
    cyc(0); chk0("sw_wr_wait", ST_MEM_WR, CW_MEM_WR);
    cyc(1); chk0("sw_wr_done", ST_MEM_WR, CW_MEM_WR);

    // illegal opcode -> TRAP, sticky until reset
    cyc(1); opcode = 6'h3F; chk0("ill_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc(1); chk0("ill_dec", ST_DECODE, CW_DECODE);
    for (int i = 0; i < 12; i++) begin
      cyc(1'($urandom_range(0, 1)));
      zero = 1'($urandom_range(0, 1));
      #1;
      chk0("trap_hold", ST_TRAP, CW_TRAP);
    end
    @(negedge clk); rst_n = 1'b0; mem_ready = 1'b1; #1;
    chk_cw("trap_rst", cw0, CW_ZERO);
    @(negedge clk); rst_n = 1'b1; opcode = OP_RTYPE; #1;
    chk0("after_rst", ST_FETCH, CW_FETCH_RDY);

    // dut1: sw with memory stuck -> 4 stall cycles then TRAP
    @(negedge clk); rst_n1 = 1'b1; mem_ready1 = 1'b1; #1;
    chk1("to_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc1(1); chk1("to_dec", ST_DECODE, CW_DECODE);
    cyc1(1); chk1("to_addr", ST_MEM_ADDR, CW_MEM_ADDR);
    for (int i = 0; i < 4; i++) begin
      cyc1(0); chk1("to_wr_wait", ST_MEM_WR, CW_MEM_WR);
    end
    cyc1(0); chk1("to_trap", ST_TRAP, CW_TRAP);
    cyc1(0); chk1("to_trap_hold", ST_TRAP, CW_TRAP);

    @(negedge clk); rst_n1 = 1'b0; #1;
    chk_cw("to_rst", cw1, CW_ZERO);
    @(negedge clk); rst_n1 = 1'b1; mem_ready1 = 1'b1; #1;
    chk1("rw_fetch", ST_FETCH, CW_FETCH_RDY);
    cyc1(1); chk1("rw_dec", ST_DECODE, CW_DECODE);
    cyc1(1); chk1("rw_addr", ST_MEM_ADDR, CW_MEM_ADDR);
    for (int i = 0; i < 3; i++) begin
      cyc1(0); chk1("rw_wr_wait", ST_MEM_WR, CW_MEM_WR);
    end
    cyc1(1); chk1("rw_wr_ready", ST_MEM_WR, CW_MEM_WR);
    cyc1(1); chk1("rw_done", ST_FETCH, CW_FETCH_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Main control unit for the multi-cycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback through one FSM.
- Drives every datapath enable and mux select.
- Supplies alu_op and use_funct to the ALU control stage. On R-type execute, the ALU control decodes funct; otherwise it passes alu_op straight to the ALU select.
- Handles a ready handshake with the unified instruction/data memory.

Parameters:
- MEM_TIMEOUT, 0, max wait cycles per memory access before trapping; 0 = wait forever.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  PC source: 0 ALU result, 1 ALUOut, 2 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  register write address: 0 rt, 1 rd
- mem_to_reg  out  1  writeback data: 0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0 PC, 1 rs
- alu_src_b  out  2  ALU B: 0 rt, 1 constant 4, 2 sign-extended imm, 3 sign-extended imm<<2
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 6 slt
- use_funct  out  1  ALU control must decode funct
- illegal  out  1  sticky trap flag
- state  out  4  current FSM state, for debug

Behaviour:
- Reset:
  - rst_n sampled low at a clk edge sets state to FETCH, clears illegal and clears the wait counter.
  - All outputs except state are forced to 0 while rst_n=0.
  - Reset mid-instruction abandons the instruction. No writes occur in the reset cycle.
- Outputs are combinational from state, opcode, zero and mem_ready. Only state, illegal and the wait counter are registered.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0.
  - pc_write = ir_write = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 goes to R_EXEC.
    - 0x23 lw and 0x2B sw go to MEM_ADDR.
    - 0x04 beq and 0x05 bne go to BRANCH.
    - 0x02 j goes to JUMP.
    - 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori go to I_EXEC.
    - Any other opcode goes to TRAP.
- R_EXEC: alu_src_a=1, alu_src_b=0, use_funct=1. Next state R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0, use_funct=1. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=add. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: i_or_d=1, mem_read=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Holds until mem_ready, then goes to FETCH. mem_write stays asserted for every wait cycle.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=0, alu_op=sub, pc_src=1.
  - pc_write = zero for beq, ~zero for bne.
  - Next state FETCH.
- JUMP: pc_src=2, pc_write=1. Next state FETCH.
- I_EXEC:
  - Drives alu_src_a=1, alu_src_b=2.
  - alu_op: addi add, slti slt, andi and, ori or. Immediate extension is the datapath's concern.
  - Next state I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, with alu_op held. Next state FETCH.
- TRAP: illegal=1 and all enables 0. Stays in TRAP until reset.
- Latency with zero-wait memory (mem_ready=1 on first request):
  - R-type 4 cycles, lw 5, sw 4, I-type 4, beq/bne 3, j 3.
  - Each wait cycle adds 1.
- Memory requests must remain stable while mem_ready=0. No request is asserted in any other state.
- Timeout (MEM_TIMEOUT>0):
  - A counter increments in FETCH, MEM_RD and MEM_WR while mem_ready=0, and resets on each state change.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP.
  - mem_ready=1 in the same cycle as the count reaching the limit completes the access normally (ready wins).
- State encoding fits in 4 bits. TRAP=4'hF. Unused encodings go to TRAP.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants
  - state enum/localparams
  - alu_op codes (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=6)
  - alu_src_b and pc_src encodings
- One sub-module, mips_op_decode: opcode goes in; it returns the DECODE next-state class, the I-type alu_op, is_bne and illegal. Purely combinational.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> outputs 0 during reset; state=FETCH with mem_read=1, pc_write=1, ir_write=1 on the first active cycle.
- add (opcode 0x00), mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB, FETCH (4 cycles); use_funct=1 in R_EXEC and R_WB; reg_write=1, reg_dst=1 only in R_WB.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD -> mem_read and i_or_d=1 stable for 4 cycles; MEM_WB has mem_to_reg=1, reg_write=1; total 8 cycles.
- beq (0x04) with zero=1, then bne (0x05) with zero=1 -> pc_write=1, pc_src=1 for beq; pc_write=0 for bne; alu_op=1 in both BRANCH cycles.
- Opcode 0x3F -> TRAP after DECODE, illegal=1 and all enables 0 for 10+ cycles; rst_n low for 1 cycle -> illegal=0, state=FETCH.
- MEM_TIMEOUT=4, sw (0x2B) with mem_ready stuck 0 -> mem_write held 4 cycles, then TRAP; repeating with mem_ready=1 on the 4th wait cycle -> completes to FETCH.
